// File: rtl/i2c_target_regs.sv
// I2C target at address I2C_ADDR with a four-entry 8-bit register file that is
// shared with an Avalon-MM slave port. SCL is input-only; SDA is open-drain via sda_oe.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_ADDR,
    S_WRITE,
    S_ACK_WRITE,
    S_READ,
    S_ACK_READ
  } state_t;

  logic       r_scl_meta, r_scl_sync, r_scl_prev;
  logic       r_sda_meta, r_sda_sync, r_sda_prev;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic       r_first_byte, w_first_byte_nxt;
  logic       r_byte_done, w_byte_done_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;

  logic [7:0] r_regs [4];
  logic       w_i2c_we;
  logic       w_av_we;
  logic       w_unused;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the synchronizer chain shifts by exactly one stage per clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_meta <= scl_in;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= sda_in;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
    end
  end

  assign w_scl_rise = ~r_scl_prev & r_scl_sync;
  assign w_scl_fall = r_scl_prev & ~r_scl_sync;
  assign w_start    = r_sda_prev & ~r_sda_sync & r_scl_sync;
  assign w_stop     = ~r_sda_prev & r_sda_sync & r_scl_sync;

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_ptr_nxt        = r_ptr;
    w_first_byte_nxt = r_first_byte;
    w_byte_done_nxt  = r_byte_done;
    w_sda_oe_nxt     = r_sda_oe;
    w_i2c_we         = 1'b0;

    if (w_start) begin
      w_state_nxt     = S_ADDR;
      w_bit_cnt_nxt   = 3'd0;
      w_byte_done_nxt = 1'b0;
      w_sda_oe_nxt    = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR, S_WRITE: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[6:0], r_sda_sync};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_byte_done_nxt = 1'b1;
          end else if (w_scl_fall && r_byte_done) begin
            w_byte_done_nxt = 1'b0;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == I2C_ADDR) begin
                w_sda_oe_nxt = 1'b1;
                w_state_nxt  = S_ACK_ADDR;
              end else begin
                w_state_nxt  = S_IDLE;
              end
            end else begin
              w_sda_oe_nxt = 1'b1;
              w_state_nxt  = S_ACK_WRITE;
              // The first byte of a write transfer is the register pointer, not data.
              if (r_first_byte) begin
                w_ptr_nxt        = r_shift[1:0];
                w_first_byte_nxt = 1'b0;
              end else begin
                w_i2c_we  = 1'b1;
                w_ptr_nxt = r_ptr + 2'd1;
              end
            end
          end
        end
        S_ACK_ADDR: begin
          if (w_scl_fall) begin
            w_bit_cnt_nxt   = 3'd0;
            w_byte_done_nxt = 1'b0;
            if (!r_shift[0]) begin
              w_sda_oe_nxt     = 1'b0;
              w_first_byte_nxt = 1'b1;
              w_state_nxt      = S_WRITE;
            end else begin
              w_shift_nxt  = r_regs[r_ptr];
              w_ptr_nxt    = r_ptr + 2'd1;
              w_sda_oe_nxt = ~r_regs[r_ptr][7];
              w_state_nxt  = S_READ;
            end
          end
        end
        S_ACK_WRITE: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt    = 1'b0;
            w_bit_cnt_nxt   = 3'd0;
            w_byte_done_nxt = 1'b0;
            w_state_nxt     = S_WRITE;
          end
        end
        S_READ: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              w_sda_oe_nxt    = 1'b0;
              w_byte_done_nxt = 1'b0;
              w_state_nxt     = S_ACK_READ;
            end else begin
              w_shift_nxt   = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt  = ~r_shift[6];
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end
        end
        S_ACK_READ: begin
          // r_byte_done here records that the initiator acknowledged the byte.
          if (w_scl_rise) begin
            if (r_sda_sync) w_state_nxt = S_IDLE;
            else            w_byte_done_nxt = 1'b1;
          end else if (w_scl_fall && r_byte_done) begin
            w_shift_nxt     = r_regs[r_ptr];
            w_ptr_nxt       = r_ptr + 2'd1;
            w_sda_oe_nxt    = ~r_regs[r_ptr][7];
            w_bit_cnt_nxt   = 3'd0;
            w_byte_done_nxt = 1'b0;
            w_state_nxt     = S_READ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_ptr        <= 2'd0;
      r_first_byte <= 1'b0;
      r_byte_done  <= 1'b0;
      r_sda_oe     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_ptr        <= w_ptr_nxt;
      r_first_byte <= w_first_byte_nxt;
      r_byte_done  <= w_byte_done_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
    end
  end

  assign w_av_we = chipselect & ~write_n;

  // NOTE: the register file is reset because software must read zeros after
  // reset; a larger memory would normally be left unreset to map onto RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_i2c_we && r_ptr == 2'(i))          r_regs[i] <= r_shift;
        else if (w_av_we && address == 2'(i))    r_regs[i] <= writedata[7:0];
      end
    end
  end

  assign readdata = {24'b0, r_regs[address]};
  assign sda_oe   = r_sda_oe;
  assign w_unused = ^writedata[31:8];

endmodule
